// File: rtl/aq_djpeg_bitstream.sv
// JPEG entropy-coded segment unpacker: strips byte stuffing, detects markers and
// presents a left-aligned 32-bit bit window to the Huffman decoder.
module aq_djpeg_bitstream (
  input  logic        clk,
  input  logic        rst,
  input  logic        ProcessInit,
  input  logic        DataInEnable,
  input  logic [7:0]  DataIn,
  output logic        DataInReady,
  input  logic        DecodeUseBit,
  input  logic [6:0]  DecodeUseWidth,
  output logic        DataOutEnable,
  output logic [31:0] DataOut,
  output logic        MarkerEnable,
  output logic [7:0]  MarkerCode,
  output logic        ImageEnd,
  output logic        WidthError
);

  localparam int unsigned BUF_W   = 64;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned WIN_W   = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned READY_MAX = BUF_W - BYTE_W;

  typedef enum logic [1:0] {
    S_DATA    = 2'd0,
    S_FF_SEEN = 2'd1,
    S_END     = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [BUF_W-1:0]   r_buf, w_buf_next;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic               r_marker_en, w_marker_en_next;
  logic [7:0]         r_marker_code, w_marker_code_next;
  logic               r_image_end, w_image_end_next;
  logic               r_width_error, w_width_error_next;

  logic               w_accept;
  logic               w_consume;
  logic [CNT_W-1:0]   w_width;
  logic [BUF_W-1:0]   w_buf_shifted;
  logic [CNT_W-1:0]   w_count_shifted;
  logic               w_append;
  logic [7:0]         w_append_byte;
  logic [WIN_W-1:0]   w_pad;

  // Handshake and window status are decoded directly from registers.
  assign DataInReady   = (r_count <= CNT_W'(READY_MAX)) && (r_state != S_END);
  assign DataOutEnable = (r_count >= CNT_W'(WIN_W)) ||
                         ((r_state == S_END) && (r_count != '0));
  assign w_pad   = ((r_state == S_END) && (r_count < CNT_W'(WIN_W))) ?
                   (32'hFFFF_FFFF >> r_count) : 32'd0;
  assign DataOut = r_buf[BUF_W-1 -: WIN_W] | w_pad;

  assign MarkerEnable = r_marker_en;
  assign MarkerCode   = r_marker_code;
  assign ImageEnd     = r_image_end;
  assign WidthError   = r_width_error;

  assign w_accept  = DataInEnable && DataInReady;
  assign w_consume = DecodeUseBit && DataOutEnable;
  assign w_width   = (DecodeUseWidth > CNT_W'(WIN_W)) ? CNT_W'(WIN_W) : DecodeUseWidth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_DATA;
      r_buf         <= '0;
      r_count       <= '0;
      r_marker_en   <= 1'b0;
      r_marker_code <= 8'h00;
      r_image_end   <= 1'b0;
      r_width_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_buf         <= w_buf_next;
      r_count       <= w_count_next;
      r_marker_en   <= w_marker_en_next;
      r_marker_code <= w_marker_code_next;
      r_image_end   <= w_image_end_next;
      r_width_error <= w_width_error_next;
    end
  end

  // Shift for the consume first, then append below the surviving bits.
  always_comb begin
    w_state_next       = r_state;
    w_marker_en_next   = 1'b0;
    w_marker_code_next = r_marker_code;
    w_image_end_next   = r_image_end;
    w_width_error_next = r_width_error;
    w_append           = 1'b0;
    w_append_byte      = DataIn;
    w_buf_shifted      = r_buf;
    w_count_shifted    = r_count;

    if (w_consume) begin
      w_buf_shifted   = r_buf << w_width;
      w_count_shifted = (r_count > w_width) ? (r_count - w_width) : '0;
      if (DecodeUseWidth > CNT_W'(WIN_W)) begin
        w_width_error_next = 1'b1;
      end
    end

    if (w_accept) begin
      case (r_state)
        S_DATA: begin
          if (DataIn == 8'hFF) begin
            w_state_next = S_FF_SEEN;
          end else begin
            w_append = 1'b1;
          end
        end
        S_FF_SEEN: begin
          if (DataIn == 8'h00) begin
            w_append      = 1'b1;
            w_append_byte = 8'hFF;
            w_state_next  = S_DATA;
          end else if (DataIn == 8'hFF) begin
            w_state_next = S_FF_SEEN;
          end else begin
            w_marker_en_next   = 1'b1;
            w_marker_code_next = DataIn;
            if (DataIn == 8'hD9) begin
              w_image_end_next = 1'b1;
              w_state_next     = S_END;
            end else begin
              w_state_next = S_DATA;
            end
          end
        end
        default: w_state_next = r_state;
      endcase
    end

    w_buf_next   = w_buf_shifted;
    w_count_next = w_count_shifted;
    if (w_append) begin
      w_buf_next   = w_buf_shifted | ({w_append_byte, 56'd0} >> w_count_shifted);
      w_count_next = w_count_shifted + CNT_W'(BYTE_W);
    end

    if (ProcessInit) begin
      w_state_next       = S_DATA;
      w_buf_next         = '0;
      w_count_next       = '0;
      w_marker_en_next   = 1'b0;
      w_marker_code_next = 8'h00;
      w_image_end_next   = 1'b0;
      w_width_error_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_bitstream.sv
// Directed self-checking bench for aq_djpeg_bitstream.
module tb_aq_djpeg_bitstream;

  logic        clk = 1'b0;
  logic        rst;
  logic        ProcessInit;
  logic        DataInEnable;
  logic [7:0]  DataIn;
  logic        DataInReady;
  logic        DecodeUseBit;
  logic [6:0]  DecodeUseWidth;
  logic        DataOutEnable;
  logic [31:0] DataOut;
  logic        MarkerEnable;
  logic [7:0]  MarkerCode;
  logic        ImageEnd;
  logic        WidthError;

  int checks = 0;
  int errors = 0;

  aq_djpeg_bitstream dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
    .DataInEnable(DataInEnable), .DataIn(DataIn), .DataInReady(DataInReady),
    .DecodeUseBit(DecodeUseBit), .DecodeUseWidth(DecodeUseWidth),
    .DataOutEnable(DataOutEnable), .DataOut(DataOut),
    .MarkerEnable(MarkerEnable), .MarkerCode(MarkerCode),
    .ImageEnd(ImageEnd), .WidthError(WidthError)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    DataInEnable = 1'b1;
    DataIn = b;
    tick();
    DataInEnable = 1'b0;
  endtask

  task automatic consume(input logic [6:0] w);
    DecodeUseBit = 1'b1;
    DecodeUseWidth = w;
    tick();
    DecodeUseBit = 1'b0;
  endtask

  task automatic do_init();
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ProcessInit = 0; DataInEnable = 0; DataIn = 0; DecodeUseBit = 0; DecodeUseWidth = 0;
    tick(); tick();
    checks++;
    if ({DataOutEnable, DataOut, MarkerEnable, MarkerCode, ImageEnd, WidthError, DataInReady}
        !== {1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: doe=%b out=%h me=%b mc=%h ie=%b we=%b rdy=%b, required 0 0 0 00 0 0 1",
               DataOutEnable, DataOut, MarkerEnable, MarkerCode, ImageEnd, WidthError, DataInReady);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    checks++;
    if (DataOutEnable !== 1'b0) begin
      errors++; $display("FAIL basic_3bytes_doe: got %b required 0", DataOutEnable);
    end
    send_byte(8'h78);
    checks++;
    if (DataOutEnable !== 1'b1 || DataOut !== 32'h12345678) begin
      errors++; $display("FAIL basic_window: doe=%b out=%h required 1 12345678", DataOutEnable, DataOut);
    end
    consume(7'd0);
    checks++;
    if (DataOut !== 32'h12345678 || dut.r_count !== 7'd32) begin
      errors++; $display("FAIL zero_width_consume: out=%h cnt=%0d required 12345678 32", DataOut, dut.r_count);
    end
  endtask

  task automatic test_consume_append();
    DecodeUseBit = 1'b1; DecodeUseWidth = 7'd4;
    DataInEnable = 1'b1; DataIn = 8'h9A;
    tick();
    DecodeUseBit = 1'b0; DataInEnable = 1'b0;
    checks++;
    if (DataOut !== 32'h23456789 || dut.r_count !== 7'd36) begin
      errors++; $display("FAIL consume_append: out=%h cnt=%0d required 23456789 36", DataOut, dut.r_count);
    end
  endtask

  task automatic test_marker();
    send_byte(8'hFF);
    checks++;
    if (MarkerEnable !== 1'b0 || dut.r_count !== 7'd36) begin
      errors++; $display("FAIL marker_ff_prefix: me=%b cnt=%0d required 0 36", MarkerEnable, dut.r_count);
    end
    send_byte(8'hD3);
    checks++;
    if (MarkerEnable !== 1'b1 || MarkerCode !== 8'hD3 || DataOut !== 32'h23456789 ||
        dut.r_count !== 7'd36) begin
      errors++; $display("FAIL marker_d3: me=%b mc=%h out=%h cnt=%0d required 1 d3 23456789 36",
                         MarkerEnable, MarkerCode, DataOut, dut.r_count);
    end
    tick();
    checks++;
    if (MarkerEnable !== 1'b0 || MarkerCode !== 8'hD3) begin
      errors++; $display("FAIL marker_pulse_end: me=%b mc=%h required 0 d3", MarkerEnable, MarkerCode);
    end
  endtask

  task automatic test_init();
    do_init();
    checks++;
    if (dut.r_count !== 7'd0 || DataOutEnable !== 1'b0 || MarkerCode !== 8'h00 ||
        DataInReady !== 1'b1 || DataOut !== 32'h0) begin
      errors++; $display("FAIL init_clear: cnt=%0d doe=%b mc=%h rdy=%b out=%h required 0 0 00 1 0",
                         dut.r_count, DataOutEnable, MarkerCode, DataInReady, DataOut);
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] seq [5] = '{8'hAB, 8'hFF, 8'h00, 8'hCD, 8'hEF};
    int pulses = 0;
    do_init();
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      if (MarkerEnable) pulses++;
    end
    checks++;
    if (DataOut !== 32'hABFFCDEF || dut.r_count !== 7'd32 || pulses != 0) begin
      errors++; $display("FAIL stuffing: out=%h cnt=%0d pulses=%0d required abffcdef 32 0",
                         DataOut, dut.r_count, pulses);
    end
  endtask

  task automatic test_fill_bytes();
    logic [7:0] seq [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33};
    int pulses = 0;
    do_init();
    for (int i = 0; i < 7; i++) begin
      send_byte(seq[i]);
      if (MarkerEnable) pulses++;
    end
    checks++;
    if (DataOut !== 32'hFF112233 || dut.r_count !== 7'd32 || pulses != 0) begin
      errors++; $display("FAIL fill_bytes: out=%h cnt=%0d pulses=%0d required ff112233 32 0",
                         DataOut, dut.r_count, pulses);
    end
  endtask

  task automatic test_full();
    do_init();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h01 + i));
    checks++;
    if (DataInReady !== 1'b1) begin
      errors++; $display("FAIL full_56_ready: got %b required 1", DataInReady);
    end
    send_byte(8'h08);
    checks++;
    if (DataInReady !== 1'b0 || dut.r_count !== 7'd64) begin
      errors++; $display("FAIL full_64: rdy=%b cnt=%0d required 0 64", DataInReady, dut.r_count);
    end
    send_byte(8'h99);
    checks++;
    if (dut.r_count !== 7'd64 || DataOut !== 32'h01020304) begin
      errors++; $display("FAIL full_reject: cnt=%0d out=%h required 64 01020304", dut.r_count, DataOut);
    end
  endtask

  task automatic test_eoi();
    do_init();
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'hD9);
    checks++;
    if (ImageEnd !== 1'b1 || DataInReady !== 1'b0 || DataOutEnable !== 1'b1 ||
        DataOut !== 32'h80FFFFFF || MarkerEnable !== 1'b1 || MarkerCode !== 8'hD9) begin
      errors++; $display("FAIL eoi: ie=%b rdy=%b doe=%b out=%h me=%b mc=%h required 1 0 1 80ffffff 1 d9",
                         ImageEnd, DataInReady, DataOutEnable, DataOut, MarkerEnable, MarkerCode);
    end
    send_byte(8'h55);
    checks++;
    if (dut.r_count !== 7'd8 || DataOut !== 32'h80FFFFFF) begin
      errors++; $display("FAIL eoi_no_accept: cnt=%0d out=%h required 8 80ffffff", dut.r_count, DataOut);
    end
    consume(7'd8);
    checks++;
    if (dut.r_count !== 7'd0 || DataOutEnable !== 1'b0 || ImageEnd !== 1'b1) begin
      errors++; $display("FAIL eoi_drain: cnt=%0d doe=%b ie=%b required 0 0 1",
                         dut.r_count, DataOutEnable, ImageEnd);
    end
  endtask

  task automatic test_width_error();
    do_init();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
    consume(7'd40);
    checks++;
    if (dut.r_count !== 7'd8 || DataOut !== 32'h9A000000 || WidthError !== 1'b1) begin
      errors++; $display("FAIL width_40: cnt=%0d out=%h we=%b required 8 9a000000 1",
                         dut.r_count, DataOut, WidthError);
    end
    consume(7'd4);
    checks++;
    if (dut.r_count !== 7'd8 || DataOut !== 32'h9A000000 || WidthError !== 1'b1) begin
      errors++; $display("FAIL consume_ignored: cnt=%0d out=%h we=%b required 8 9a000000 1",
                         dut.r_count, DataOut, WidthError);
    end
    do_init();
    checks++;
    if (WidthError !== 1'b0 || dut.r_count !== 7'd0 || DataInReady !== 1'b1 || DataOutEnable !== 1'b0) begin
      errors++; $display("FAIL width_init: we=%b cnt=%0d rdy=%b doe=%b required 0 0 1 0",
                         WidthError, dut.r_count, DataInReady, DataOutEnable);
    end
  endtask

  task automatic test_init_priority();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    ProcessInit = 1'b1; DataInEnable = 1'b1; DataIn = 8'h55; DecodeUseBit = 1'b1; DecodeUseWidth = 7'd8;
    tick();
    ProcessInit = 1'b0; DataInEnable = 1'b0; DecodeUseBit = 1'b0;
    checks++;
    if (dut.r_count !== 7'd0 || DataOut !== 32'h0) begin
      errors++; $display("FAIL init_priority: cnt=%0d out=%h required 0 0", dut.r_count, DataOut);
    end
  endtask

  task automatic test_mid_reset();
    send_byte(8'hAA); send_byte(8'hFF);
    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'hD3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    checks++;
    if (DataOut !== 32'hD3010203 || DataOutEnable !== 1'b1 || MarkerCode !== 8'h00) begin
      errors++; $display("FAIL mid_reset: out=%h doe=%b mc=%h required d3010203 1 00",
                         DataOut, DataOutEnable, MarkerCode);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_consume_append();
    test_marker();
    test_init();
    test_stuffing();
    test_fill_bytes();
    test_full();
    test_eoi();
    test_width_error();
    test_init_priority();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_bitstream.md
AQ_DJPEG_BITSTREAM -- requirements
Module: aq_djpeg_bitstream

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ProcessInit  input  1  synchronous clear at the start of each image.
REQ-005 DataInEnable  input  1  entropy-coded byte valid.
REQ-006 DataIn  input  8  entropy-coded byte, as it appears in the file.
REQ-007 DataInReady  output  1  byte is accepted when DataInEnable and DataInReady are both high.
REQ-008 DecodeUseBit  input  1  Huffman decoder consumes bits this cycle.
REQ-009 DecodeUseWidth  input  7  number of bits consumed.
REQ-010 DataOutEnable  output  1  DataOut window is valid.
REQ-011 DataOut  output  32  bit window, MSB-first; bit 31 is the next unconsumed bit.
REQ-012 MarkerEnable  output  1  one-cycle pulse when a marker is detected.
REQ-013 MarkerCode  output  8  second byte of the detected marker; held until the next marker.
REQ-014 ImageEnd  output  1  level; EOI (0xFFD9) has been seen.
REQ-015 WidthError  output  1  sticky flag; DecodeUseWidth was greater than 32.

Function
REQ-016 Buffer: 64-bit left-aligned shift register buf plus a 7-bit count (0..64); DataOut SHALL equal buf[63:32].
REQ-017 DataInReady SHALL be (count <= 56) & (state != END), driven combinationally from registers.
REQ-018 State machine has three states: DATA, FF_SEEN, END; reset state is DATA.
REQ-019 DATA state, accepted byte:
- byte != 0xFF -> append it at bit position 63-count; count += 8.
- byte == 0xFF -> do not append; go to FF_SEEN.
REQ-020 FF_SEEN state, accepted byte:
- 0x00 -> append 0xFF; go to DATA.
- 0xFF -> fill byte; stay in FF_SEEN; no append.
- 0xD9 -> pulse MarkerEnable; MarkerCode=0xD9; ImageEnd=1; go to END.
- any other value (including RST 0xD0-0xD7) -> pulse MarkerEnable; MarkerCode=byte; go to DATA; no append.
REQ-021 END state SHALL accept no bytes; bits beyond count SHALL read as 1 (pad ones) in DataOut.
REQ-022 DataOutEnable SHALL be (count >= 32) | (state==END & count > 0).
REQ-023 Consume: when DecodeUseBit & DataOutEnable, buf shifts left by w bits with 0 fill and count -= w, where w = min(DecodeUseWidth, 32).
- In END, count saturates at 0.
- DecodeUseBit while DataOutEnable is 0 SHALL be ignored.
- w = 0 SHALL be a no-op.
REQ-024 DecodeUseWidth > 32 SHALL set WidthError until ProcessInit or rst.
REQ-025 Simultaneous append and consume: apply the shift first, then append the byte at position 63-(count-w); new count = count - w + 8.
REQ-026 Latency: a byte accepted or a consume in cycle N SHALL be reflected in DataOut, DataOutEnable and DataInReady at cycle N+1.
REQ-027 ProcessInit SHALL have priority over input and consume in the same cycle and SHALL clear:
- buf, count, state (to DATA);
- ImageEnd, WidthError, MarkerCode, MarkerEnable.

Reset
REQ-028 While rst is high:
- buf=0, count=0, state=DATA;
- DataOutEnable=0, DataOut=0, MarkerEnable=0, MarkerCode=0x00, ImageEnd=0, WidthError=0;
- DataInReady=1.
REQ-029 Deassertion of rst mid-stream SHALL discard all buffered bits; the first accepted byte afterwards is treated as the start of data.

Verification
REQ-030 Feed 0x12,0x34,0x56,0x78 -> DataOutEnable=1 one cycle after the 4th byte, DataOut=0x12345678.
REQ-031 Feed 0xAB,0xFF,0x00,0xCD,0xEF -> DataOut=0xABFFCDEF with count=32, and no MarkerEnable pulse.
REQ-032 With window 0x12345678, assert DecodeUseBit with width 4 while feeding byte 0x9A -> next cycle DataOut=0x23456789, count=36.
REQ-033 Feed 0xFF,0xD3 mid-stream -> one MarkerEnable pulse with MarkerCode=0xD3; buffered bits unchanged.
REQ-034 Feed 0x80,0xFF,0xD9 -> ImageEnd=1, DataInReady=0, DataOutEnable=1, DataOut=0x80FFFFFF; consume width 8 -> count=0 and DataOutEnable=0.
REQ-035 Width 40 consume -> exactly 32 bits removed and WidthError=1; ProcessInit -> all state cleared, DataInReady=1.
